// File: rtl/calculadora_seq.sv
// calculadora_seq: button-driven unsigned calculator with registered outputs.
// Add/subtract finish one cycle after the press. Multiply (shift-add) and
// divide (restoring) produce one bit per cycle. A press is the falling edge
// of an active-low button. b_lig toggles power and aborts any operation.
module calculadora_seq #(
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           b_lig,
  input  logic           b_soma,
  input  logic           b_sub,
  input  logic           b_multi,
  input  logic           b_div,
  output logic [2*W-1:0] Y,
  output logic           sinal,
  output logic           EN,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    LIGADO    = 3'd1,
    SOMA      = 3'd2,
    SUB       = 3'd3,
    MULTI     = 3'd4,
    DIV       = 3'd5
  } state_t;

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  // Registered state
  state_t           state_r;
  logic [4:0]       hist_r;
  logic [W-1:0]     a_r, b_r;
  logic [2*W-1:0]   p_r, m_r;
  logic [W-1:0]     q_r, rem_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic [2*W-1:0]   y_r;
  logic             sinal_r, en_r, busy_r, done_r, err_r;

  // Next-state values
  state_t           state_nxt;
  logic [W-1:0]     a_nxt, b_nxt;
  logic [2*W-1:0]   p_nxt, m_nxt;
  logic [W-1:0]     q_nxt, rem_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             run_nxt;
  logic [2*W-1:0]   y_nxt;
  logic             sinal_nxt, en_nxt, busy_nxt, done_nxt, err_nxt;

  // Press detection and datapath helpers
  logic [4:0]       btn_s, press_s;
  logic             lig_press_s, op_press_s;
  state_t           op_sel_s;
  logic [W:0]       sum_s;
  logic [W-1:0]     diff_s;
  logic             neg_s;
  logic [2*W-1:0]   mul_p_s;
  logic [W:0]       div_sh_s, div_diff_s;
  logic             div_ge_s;
  logic [W-1:0]     div_rem_s, div_quo_s;

  assign btn_s       = {b_lig, b_soma, b_sub, b_multi, b_div};
  assign press_s     = hist_r & ~btn_s;
  assign lig_press_s = press_s[4];
  assign op_press_s  = |press_s[3:0];

  assign Y     = y_r;
  assign sinal = sinal_r;
  assign EN    = en_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;

  // Pick the highest-priority operation among simultaneous presses
  always_comb begin
    op_sel_s = SOMA;
    if (press_s[3]) begin
      op_sel_s = SOMA;
    end else if (press_s[2]) begin
      op_sel_s = SUB;
    end else if (press_s[1]) begin
      op_sel_s = MULTI;
    end else begin
      op_sel_s = DIV;
    end
  end

  // Arithmetic for one step of each operation, from the latched operands
  always_comb begin
    sum_s      = {1'b0, a_r} + {1'b0, b_r};
    neg_s      = (b_r > a_r);
    diff_s     = neg_s ? (b_r - a_r) : (a_r - b_r);
    mul_p_s    = q_r[0] ? (p_r + m_r) : p_r;
    // rem < divisor, so the shifted remainder minus divisor fits in W+1 signed bits
    div_sh_s   = {rem_r, q_r[W-1]};
    div_diff_s = div_sh_s - {1'b0, b_r};
    div_ge_s   = ~div_diff_s[W];
    div_rem_s  = div_ge_s ? div_diff_s[W-1:0] : div_sh_s[W-1:0];
    div_quo_s  = {q_r[W-2:0], div_ge_s};
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    p_nxt     = p_r;
    m_nxt     = m_r;
    q_nxt     = q_r;
    rem_nxt   = rem_r;
    cnt_nxt   = cnt_r;
    run_nxt   = run_r;
    y_nxt     = y_r;
    sinal_nxt = sinal_r;
    en_nxt    = en_r;
    err_nxt   = err_r;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state_r)
      DESLIGADO: begin
        en_nxt    = 1'b0;
        y_nxt     = {(2*W){1'b0}};
        sinal_nxt = 1'b0;
        err_nxt   = 1'b0;
        run_nxt   = 1'b0;
        if (lig_press_s) begin
          state_nxt = LIGADO;
          en_nxt    = 1'b1;
        end else begin
          state_nxt = DESLIGADO;
        end
      end

      LIGADO, SOMA, SUB, MULTI, DIV: begin
        if (lig_press_s) begin
          // Power off, abandoning any computation without a done pulse
          state_nxt = DESLIGADO;
          en_nxt    = 1'b0;
          y_nxt     = {(2*W){1'b0}};
          sinal_nxt = 1'b0;
          err_nxt   = 1'b0;
          run_nxt   = 1'b0;
        end else if (op_press_s && !busy_r) begin
          // Latch operands and (re)start the selected operation
          state_nxt = op_sel_s;
          a_nxt     = A;
          b_nxt     = B;
          p_nxt     = {(2*W){1'b0}};
          m_nxt     = {{W{1'b0}}, A};
          q_nxt     = (op_sel_s == DIV) ? A : B;
          rem_nxt   = {W{1'b0}};
          cnt_nxt   = {CW{1'b0}};
          run_nxt   = 1'b1;
          err_nxt   = 1'b0;
        end else if (run_r) begin
          case (state_r)
            SOMA: begin
              y_nxt     = {{(W-1){1'b0}}, sum_s};
              sinal_nxt = 1'b0;
              done_nxt  = 1'b1;
              run_nxt   = 1'b0;
            end
            SUB: begin
              y_nxt     = {{W{1'b0}}, diff_s};
              sinal_nxt = neg_s;
              done_nxt  = 1'b1;
              run_nxt   = 1'b0;
            end
            MULTI: begin
              p_nxt = mul_p_s;
              m_nxt = m_r << 1;
              q_nxt = q_r >> 1;
              if (cnt_r == LAST_STEP) begin
                y_nxt     = mul_p_s;
                sinal_nxt = 1'b0;
                done_nxt  = 1'b1;
                run_nxt   = 1'b0;
              end else begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt_r + 1'b1;
              end
            end
            DIV: begin
              if ((cnt_r == {CW{1'b0}}) && (b_r == {W{1'b0}})) begin
                // Division by zero: report immediately, no iteration
                y_nxt     = {(2*W){1'b0}};
                sinal_nxt = 1'b0;
                err_nxt   = 1'b1;
                done_nxt  = 1'b1;
                run_nxt   = 1'b0;
              end else begin
                rem_nxt = div_rem_s;
                q_nxt   = div_quo_s;
                if (cnt_r == LAST_STEP) begin
                  y_nxt     = {div_rem_s, div_quo_s};
                  sinal_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  run_nxt   = 1'b0;
                end else begin
                  busy_nxt = 1'b1;
                  cnt_nxt  = cnt_r + 1'b1;
                end
              end
            end
            default: begin
              run_nxt = 1'b0;
            end
          endcase
        end else begin
          // Idle: result holds until the next press
          run_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = DESLIGADO;
        en_nxt    = 1'b0;
        y_nxt     = {(2*W){1'b0}};
        sinal_nxt = 1'b0;
        err_nxt   = 1'b0;
        run_nxt   = 1'b0;
      end
    endcase
  end

  // State, datapath, button history and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= DESLIGADO;
      hist_r  <= 5'b11111;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      p_r     <= {(2*W){1'b0}};
      m_r     <= {(2*W){1'b0}};
      q_r     <= {W{1'b0}};
      rem_r   <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      run_r   <= 1'b0;
      y_r     <= {(2*W){1'b0}};
      sinal_r <= 1'b0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      hist_r  <= btn_s;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      p_r     <= p_nxt;
      m_r     <= m_nxt;
      q_r     <= q_nxt;
      rem_r   <= rem_nxt;
      cnt_r   <= cnt_nxt;
      run_r   <= run_nxt;
      y_r     <= y_nxt;
      sinal_r <= sinal_nxt;
      en_r    <= en_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
      err_r   <= err_nxt;
    end
  end

endmodule
